load_return_unit: RTL

- Sits directly downstream of the stage-3 load-select decode.
- Consumes the 3-bit load-select code plus the low address bits and destination register of a load, then waits a variable number of cycles for the data-memory read response.
- Aligns and sign/zero-extends the returned word and holds the result for writeback under a valid/ready handshake.
- Stalls the pipeline while a load is outstanding or its result is unconsumed.

---
 rtl/load_return_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/load_return_unit.sv
// load_return_unit
//   Collects a decoded load from stage 3 and waits a variable number of cycles
//   for the data-memory response. It then aligns and extends the returned word
//   and holds the result for writeback under a valid/ready handshake. While a
//   load is outstanding or its result is unconsumed, the unit stalls upstream.
//
// Parameters
//   TIMEOUT_CYCLES  cycles in WAIT without a response before forced completion
//   CNT_W           wait-counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       stage 3 presents a memory op
//   ld_sel[2:0]     000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, others not a load
//   addr_lo[1:0]    byte offset of the load
//   req_rd[4:0]     destination register
//   dmem_rdata[31:0], dmem_rvalid   memory read response
//   wb_ready        writeback accepts the result
//   stall           upstream must hold (combinational)
//   wb_valid, wb_data[31:0], wb_rd[4:0], misaligned, timeout   registered result
module load_return_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  ld_sel,
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  req_rd,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  input  logic        wb_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        misaligned,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        sel_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;

  logic              is_load;
  logic              handshake;
  logic              accept;
  logic              cnt_expired;
  logic              finish_wait;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ext_data;
  logic              ext_misalign;

  assign is_load     = req_valid && (ld_sel <= 3'b100);
  assign handshake   = (state_q == S_RESP) && wb_ready;
  // A new load may enter in the same cycle the previous result retires.
  assign accept      = is_load && ((state_q == S_IDLE) || handshake);
  assign cnt_expired = (cnt_q == CNT_LAST);
  assign finish_wait = (state_q == S_WAIT) && (dmem_rvalid || cnt_expired);

  // Releasing stall in the handshake cycle lets upstream advance without a bubble.
  assign stall = (state_q == S_WAIT) || ((state_q == S_RESP) && !wb_ready);

  // Byte/half selection uses the offset latched at acceptance, not the live one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ext_data     = '0;
    ext_misalign = 1'b0;
    unique case (off_q)
      2'd0:    byte_v = dmem_rdata[7:0];
      2'd1:    byte_v = dmem_rdata[15:8];
      2'd2:    byte_v = dmem_rdata[23:16];
      default: byte_v = dmem_rdata[31:24];
    endcase
    half_v = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (sel_q)
      3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  begin
                 ext_data     = {{16{half_v[15]}}, half_v};
                 ext_misalign = off_q[0];
               end
      3'b010:  begin
                 ext_data     = dmem_rdata;
                 ext_misalign = (off_q != 2'd0);
               end
      3'b011:  ext_data = {24'd0, byte_v};
      3'b100:  begin
                 ext_data     = {16'd0, half_v};
                 ext_misalign = off_q[0];
               end
      default: ext_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (dmem_rvalid || cnt_expired) state_d = S_RESP;
      S_RESP:  if (wb_ready) state_d = accept ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (accept) begin
        sel_q <= ld_sel;
        off_q <= addr_lo;
        rd_q  <= req_rd;
        cnt_q <= '0;
      end else if ((state_q == S_WAIT) && !dmem_rvalid && !cnt_expired) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (finish_wait) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        if (dmem_rvalid) begin
          // A misaligned load still drains the response but returns zero.
          wb_data    <= ext_misalign ? 32'd0 : ext_data;
          misaligned <= ext_misalign;
          timeout    <= 1'b0;
        end else begin
          wb_data    <= '0;
          misaligned <= 1'b0;
          timeout    <= 1'b1;
        end
      end else if (handshake) begin
        wb_valid   <= 1'b0;
        misaligned <= 1'b0;
        timeout    <= 1'b0;
      end
    end
  end

endmodule
